lsu_mem_initiator: RTL

//  Load/store initiator that drives the byte-addressable data memory port from the execute stage.
//  - Accepts one load/store request at a time over a valid/ready handshake.
//  - Checks alignment, address range and funct3; sequences the memory read/write enables;

---
 rtl/lsu_mem_initiator.sv | 112 +++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the memory stage and the data memory port.
// Validates each request, sequences read/write enables and returns a registered response.
module lsu_mem_initiator #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000),
  parameter int                MEM_BYTES = 4096,
  parameter int                READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0]  RW_LAST = 4'(READ_WAIT - 1);
  localparam logic [AWIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (AWIDTH+1)'(MEM_BYTES);

  state_t      state, state_nxt;
  logic [3:0]  rd_cnt;
  logic        f3_bad, misal, oor;
  logic [1:0]  err_c;
  logic [AWIDTH:0] addr_end;

  // Request classification, evaluated on the cycle the request is presented
  always_comb begin
    addr_end = {1'b0, req_addr_i} + (AWIDTH+1)'(3);
    if (req_we_i) f3_bad = !(req_funct3_i inside {3'b000, 3'b001, 3'b010});
    else          f3_bad = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
            ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    oor   = (req_addr_i < BASE_ADDR) || (addr_end >= LIMIT);
    if      (f3_bad) err_c = 2'd3;
    else if (misal)  err_c = 2'd1;
    else if (oor)    err_c = 2'd2;
    else             err_c = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = (err_c != 2'd0) ? RESP : ACCESS;
      ACCESS:  if (mem_write_en_o || (rd_cnt == RW_LAST)) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_o    <= '0;
      rsp_err_o      <= '0;
      mem_addr_o     <= BASE_ADDR;
      mem_data_o     <= '0;
      mem_funct3_o   <= '0;
      mem_read_en_o  <= 1'b0;
      mem_write_en_o <= 1'b0;
      rd_cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= err_c;
          if (err_c == 2'd0) begin
            mem_addr_o     <= req_addr_i;
            mem_data_o     <= req_wdata_i;
            mem_funct3_o   <= req_funct3_i;
            mem_write_en_o <= req_we_i;
            mem_read_en_o  <= !req_we_i;
            rd_cnt         <= '0;
          end
        end
        ACCESS: begin
          if (mem_write_en_o) mem_write_en_o <= 1'b0;
          else begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == RW_LAST) begin
              mem_read_en_o <= 1'b0;
              rsp_rdata_o   <= mem_data_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
